// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte-stream requesters.
// A grant lasts for a whole packet (ends on req_last) or at most MAX_BURST bytes.
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       tx_ready,
   output logic                       tx_send,
   output logic [7:0]                 tx_data,
   output logic                       grant_valid,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int         ID_W      = $clog2(NUM_REQ);
   localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SEND,
      S_WAIT_LOW,
      S_WAIT_HIGH
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic              grant_valid_q, grant_valid_d;
   logic [ID_W-1:0]   last_id_q, last_id_d;
   logic [7:0]        burst_cnt_q, burst_cnt_d;
   logic              last_q, last_d;
   logic [7:0]        tx_data_q, tx_data_d;

   logic [7:0]        lane_data [NUM_REQ];
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   cand;
   logic              found;
   logic              accept;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane_data[gi] = req_data[8*gi +: 8];
   end

   // Round-robin search starting just after the previous owner.
   always_comb begin
      winner = last_id_q;
      cand   = '0;
      found  = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((int'(last_id_q) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   assign accept = (state_q == S_FETCH) && req_valid[grant_id_q] && tx_ready;

   always_comb begin
      req_ready = '0;
      if (state_q == S_FETCH) begin
         req_ready[grant_id_q] = req_valid[grant_id_q] & tx_ready;
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_id_d    = grant_id_q;
      grant_valid_d = grant_valid_q;
      last_id_d     = last_id_q;
      burst_cnt_d   = burst_cnt_q;
      last_d        = last_q;
      tx_data_d     = tx_data_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_id_d    = winner;
               grant_valid_d = 1'b1;
               burst_cnt_d   = 8'd0;
               state_d       = S_FETCH;
            end
         end
         S_FETCH: begin
            // A stalled requester keeps the grant; the packet is not abandoned.
            if (accept) begin
               tx_data_d   = lane_data[grant_id_q];
               last_d      = req_last[grant_id_q];
               burst_cnt_d = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;
               state_d     = S_SEND;
            end
         end
         S_SEND: begin
            state_d = S_WAIT_LOW;
         end
         S_WAIT_LOW: begin
            if (!tx_ready) begin
               state_d = S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: begin
            if (tx_ready) begin
               if (last_q || (burst_cnt_q == BURST_MAX)) begin
                  last_id_d     = grant_id_q;
                  grant_valid_d = 1'b0;
                  state_d       = S_IDLE;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
         last_id_q     <= ID_W'(NUM_REQ - 1);
         burst_cnt_q   <= 8'd0;
         last_q        <= 1'b0;
         tx_data_q     <= 8'h00;
      end else begin
         state_q       <= state_d;
         grant_id_q    <= grant_id_d;
         grant_valid_q <= grant_valid_d;
         last_id_q     <= last_id_d;
         burst_cnt_q   <= burst_cnt_d;
         last_q        <= last_d;
         tx_data_q     <= tx_data_d;
      end
   end

   assign tx_send     = (state_q == S_SEND);
   assign tx_data     = tx_data_q;
   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;

endmodule
